// File: rtl/mem_arbiter_pkg.sv
// Definitions shared by the data-memory arbiter: FSM state encoding and
// read-owner encoding. The optional host lock feature is MEM_ARB_LOCK_EN.
package mem_arbiter_pkg;

   // Which requester currently holds tie-break priority, or host exclusive.
   typedef enum logic [1:0] {
      ARB_CORE_PRI = 2'd0,
      ARB_HOST_PRI = 2'd1,
      ARB_LOCKED   = 2'd2
   } arb_state_t;

   // Requester encoding, also used as index into req/gnt vectors.
   localparam logic ARB_CORE = 1'b0;
   localparam logic ARB_HOST = 1'b1;

   // Priority holder for a given state; the locked state favours the host.
   function automatic logic prio_of(input arb_state_t s);
      return (s == ARB_CORE_PRI) ? ARB_CORE : ARB_HOST;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way priority picker: grants the single requester, or the priority
// holder when both request. Purely combinational; at most one grant bit.
module mem_arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt
);

   // Pick the winner from the request vector and the priority holder.
   always_comb begin
      gnt = 2'b00;
      if (req[ARB_CORE] && req[ARB_HOST]) begin
         gnt[prio] = 1'b1;
      end else if (req[ARB_CORE]) begin
         gnt[ARB_CORE] = 1'b1;
      end else if (req[ARB_HOST]) begin
         gnt[ARB_HOST] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous data memory between
// the core lw/sw port and the host loader port. One-beat req/gnt transfers,
// fixed one-cycle read return, saturating contention counter.
// Optional feature: define MEM_ARB_LOCK_EN to let the host take exclusive
// ownership with HostLock; otherwise HostLock is ignored.
//
// Handshake: a requester raises Req with We/Addr/WData stable and holds them
// until Gnt is seen high in the same cycle; that cycle is the transfer. A
// read granted in cycle N returns RValid/RData in cycle N+1 only.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int W  = 8,
   parameter int AW = 8,
   parameter int CW = 8
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          CoreReq,
   input  logic          CoreWe,
   input  logic [AW-1:0] CoreAddr,
   input  logic [W-1:0]  CoreWData,
   output logic          CoreGnt,
   output logic          CoreRValid,
   output logic [W-1:0]  CoreRData,
   input  logic          HostReq,
   input  logic          HostWe,
   input  logic [AW-1:0] HostAddr,
   input  logic [W-1:0]  HostWData,
   output logic          HostGnt,
   output logic          HostRValid,
   output logic [W-1:0]  HostRData,
   input  logic          HostLock,
   output logic [AW-1:0] MemAddr,
   output logic          MemWe,
   output logic [W-1:0]  MemWData,
   input  logic [W-1:0]  MemRData,
   output logic [CW-1:0] ConflictCnt,
   output arb_state_t    DbgState
);

   arb_state_t    state_q, state_d;
   logic          rd_pend_q, rd_pend_d;
   logic          rd_owner_q, rd_owner_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [CW-1:0] conflict_q, conflict_d;

   logic [1:0]    req_vec;
   logic [1:0]    gnt_vec;
   logic          prio_bit;

`ifndef MEM_ARB_LOCK_EN
   logic          unused_host_lock;
   assign unused_host_lock = HostLock;
`endif

   // Qualify requests: nothing is granted while reset is asserted, and the
   // core is shut out while the host holds the lock.
   always_comb begin
      req_vec           = 2'b00;
      req_vec[ARB_CORE] = CoreReq & Reset & (state_q != ARB_LOCKED);
      req_vec[ARB_HOST] = HostReq & Reset;
      prio_bit          = prio_of(state_q);
   end

   mem_arb_pick u_pick (
      .req  (req_vec),
      .prio (prio_bit),
      .gnt  (gnt_vec)
   );

   // Route the winner onto the memory port; idle cycles keep the address.
   always_comb begin
      CoreGnt    = gnt_vec[ARB_CORE];
      HostGnt    = gnt_vec[ARB_HOST];
      MemAddr    = mem_addr_q;
      MemWe      = 1'b0;
      MemWData   = '0;
      if (gnt_vec[ARB_CORE]) begin
         MemAddr  = CoreAddr;
         MemWe    = CoreWe;
         MemWData = CoreWData;
      end else if (gnt_vec[ARB_HOST]) begin
         MemAddr  = HostAddr;
         MemWe    = HostWe;
         MemWData = HostWData;
      end
      mem_addr_d = MemAddr;
   end

   // Next-state: hand priority to the other side after every grant.
   always_comb begin
      state_d = state_q;
      if (gnt_vec[ARB_CORE]) begin
         state_d = ARB_HOST_PRI;
      end else if (gnt_vec[ARB_HOST]) begin
         state_d = ARB_CORE_PRI;
      end
`ifdef MEM_ARB_LOCK_EN
      if (gnt_vec[ARB_HOST] && HostLock) begin
         state_d = ARB_LOCKED;
      end
      if (state_q == ARB_LOCKED) begin
         state_d = HostLock ? ARB_LOCKED : ARB_CORE_PRI;
      end
`endif
   end

   // Read-return bookkeeping and the saturating contention counter.
   always_comb begin
      rd_pend_d  = (gnt_vec[ARB_CORE] & ~CoreWe) | (gnt_vec[ARB_HOST] & ~HostWe);
      rd_owner_d = rd_owner_q;
      if (gnt_vec[ARB_HOST]) begin
         rd_owner_d = ARB_HOST;
      end else if (gnt_vec[ARB_CORE]) begin
         rd_owner_d = ARB_CORE;
      end
      conflict_d = conflict_q;
      if (CoreReq && HostReq && (state_q != ARB_LOCKED) && (conflict_q != '1)) begin
         conflict_d = conflict_q + CW'(1);
      end
   end

   // Read data is steered to the owner of last cycle's read grant only.
   always_comb begin
      CoreRValid  = rd_pend_q && (rd_owner_q == ARB_CORE);
      HostRValid  = rd_pend_q && (rd_owner_q == ARB_HOST);
      CoreRData   = CoreRValid ? MemRData : '0;
      HostRData   = HostRValid ? MemRData : '0;
      ConflictCnt = conflict_q;
      DbgState    = state_q;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= ARB_CORE_PRI;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= ARB_CORE;
         mem_addr_q <= '0;
         conflict_q <= '0;
      end else begin
         state_q    <= state_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
         mem_addr_q <= mem_addr_d;
         conflict_q <= conflict_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter with a small synchronous memory
// model. Optional lock sequence runs when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   logic       Clk, Reset;
   logic       CoreReq, CoreWe, CoreGnt, CoreRValid;
   logic [7:0] CoreAddr, CoreWData, CoreRData;
   logic       HostReq, HostWe, HostGnt, HostRValid, HostLock;
   logic [7:0] HostAddr, HostWData, HostRData;
   logic [7:0] MemAddr, MemWData, MemRData, ConflictCnt;
   logic       MemWe;
   arb_state_t DbgState;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic c_req; logic c_we; logic [7:0] c_addr; logic [7:0] c_wd;
      logic h_req; logic h_we; logic [7:0] h_addr; logic [7:0] h_wd;
      logic e_cg;  logic e_hg; logic e_we; logic [7:0] e_addr; logic [7:0] e_wd;
      logic e_crv; logic [7:0] e_crd; logic e_hrv; logic [7:0] e_hrd;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t vt [16];
   logic [7:0] mem [256];

   mem_arbiter dut (
      .Clk(Clk), .Reset(Reset),
      .CoreReq(CoreReq), .CoreWe(CoreWe), .CoreAddr(CoreAddr), .CoreWData(CoreWData),
      .CoreGnt(CoreGnt), .CoreRValid(CoreRValid), .CoreRData(CoreRData),
      .HostReq(HostReq), .HostWe(HostWe), .HostAddr(HostAddr), .HostWData(HostWData),
      .HostGnt(HostGnt), .HostRValid(HostRValid), .HostRData(HostRData),
      .HostLock(HostLock),
      .MemAddr(MemAddr), .MemWe(MemWe), .MemWData(MemWData), .MemRData(MemRData),
      .ConflictCnt(ConflictCnt), .DbgState(DbgState)
   );

   // Clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Synchronous single-port memory model, preloaded while reset is low.
   always @(posedge Clk) begin
      if (!Reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[8'h10] <= 8'hA5;
         mem[8'h30] <= 8'h5A;
         MemRData   <= 8'h00;
      end else begin
         if (MemWe) mem[MemAddr] <= MemWData;
         MemRData <= mem[MemAddr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                        input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd,
                        input logic hl);
      CoreReq = cr; CoreWe = cw; CoreAddr = ca; CoreWData = cd;
      HostReq = hr; HostWe = hw; HostAddr = ha; HostWData = hd;
      HostLock = hl;
   endtask

   // Advance one cycle with new inputs; caller checks at the falling edge.
   task automatic cycle(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                        input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd,
                        input logic hl);
      @(posedge Clk);
      #1;
      drive(cr, cw, ca, cd, hr, hw, ha, hd, hl);
      @(negedge Clk);
   endtask

   task automatic reset_pulse();
      @(negedge Clk);
      drive(F, F, 8'h00, 8'h00, F, F, 8'h00, 8'h00, F);
      Reset = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
   endtask

   initial begin
      // c_req c_we c_addr c_wd | h_req h_we h_addr h_wd | cg hg we addr wd | crv crd hrv hrd | cnt
      vt[0]  = '{T,F,8'h10,8'h00, T,F,8'h30,8'h00, T,F,F,8'h10,8'h00, F,8'h00,F,8'h00, 8'd0};
      vt[1]  = '{T,F,8'h10,8'h00, F,F,8'h00,8'h00, T,F,F,8'h10,8'h00, T,8'hA5,F,8'h00, 8'd1};
      vt[2]  = '{F,F,8'h00,8'h00, F,F,8'h00,8'h00, F,F,F,8'h10,8'h00, T,8'hA5,F,8'h00, 8'd1};
      vt[3]  = '{T,F,8'h10,8'h00, T,F,8'h30,8'h00, F,T,F,8'h30,8'h00, F,8'h00,F,8'h00, 8'd1};
      vt[4]  = '{F,F,8'h00,8'h00, T,T,8'h20,8'h3C, F,T,T,8'h20,8'h3C, F,8'h00,T,8'h5A, 8'd2};
      vt[5]  = '{T,F,8'h20,8'h00, F,F,8'h00,8'h00, T,F,F,8'h20,8'h00, F,8'h00,F,8'h00, 8'd2};
      vt[6]  = '{F,F,8'h00,8'h00, F,F,8'h00,8'h00, F,F,F,8'h20,8'h00, T,8'h3C,F,8'h00, 8'd2};
      vt[7]  = '{T,T,8'h40,8'h77, T,F,8'h10,8'h00, F,T,F,8'h10,8'h00, F,8'h00,F,8'h00, 8'd2};
      vt[8]  = '{T,T,8'h40,8'h77, T,F,8'h10,8'h00, T,F,T,8'h40,8'h77, F,8'h00,T,8'hA5, 8'd3};
      vt[9]  = '{F,F,8'h00,8'h00, T,F,8'h40,8'h00, F,T,F,8'h40,8'h00, F,8'h00,F,8'h00, 8'd4};
      vt[10] = '{F,F,8'h00,8'h00, F,F,8'h00,8'h00, F,F,F,8'h40,8'h00, F,8'h00,T,8'h77, 8'd4};
      vt[11] = '{T,F,8'h30,8'h00, T,F,8'h10,8'h00, T,F,F,8'h30,8'h00, F,8'h00,F,8'h00, 8'd4};
      vt[12] = '{F,F,8'h00,8'h00, F,F,8'h00,8'h00, F,F,F,8'h30,8'h00, T,8'h5A,F,8'h00, 8'd5};
      vt[13] = '{T,T,8'h50,8'h11, T,F,8'h30,8'h00, F,T,F,8'h30,8'h00, F,8'h00,F,8'h00, 8'd5};
      vt[14] = '{F,F,8'h00,8'h00, F,F,8'h00,8'h00, F,F,F,8'h30,8'h00, F,8'h00,T,8'h5A, 8'd6};
      vt[15] = '{T,F,8'h10,8'h00, T,F,8'h20,8'h00, T,F,F,8'h10,8'h00, F,8'h00,F,8'h00, 8'd6};

      // Reset with both requesting: nothing may be granted.
      Reset = 1'b0;
      drive(T, F, 8'h10, 8'h00, T, F, 8'h30, 8'h00, F);
      repeat (3) @(negedge Clk);
      chk("rst_core_gnt", 32'(CoreGnt), 32'd0);
      chk("rst_host_gnt", 32'(HostGnt), 32'd0);
      chk("rst_core_rvalid", 32'(CoreRValid), 32'd0);
      chk("rst_host_rvalid", 32'(HostRValid), 32'd0);
      chk("rst_mem_we", 32'(MemWe), 32'd0);
      chk("rst_conflict", 32'(ConflictCnt), 32'd0);
      chk("rst_state", 32'(DbgState), 32'(ARB_CORE_PRI));
      drive(F, F, 8'h00, 8'h00, F, F, 8'h00, 8'h00, F);
      Reset = 1'b1;

      // Directed vector table.
      for (int i = 0; i < 16; i++) begin
         cycle(vt[i].c_req, vt[i].c_we, vt[i].c_addr, vt[i].c_wd,
               vt[i].h_req, vt[i].h_we, vt[i].h_addr, vt[i].h_wd, F);
         chk($sformatf("v%0d_core_gnt", i), 32'(CoreGnt), 32'(vt[i].e_cg));
         chk($sformatf("v%0d_host_gnt", i), 32'(HostGnt), 32'(vt[i].e_hg));
         chk($sformatf("v%0d_mem_we", i), 32'(MemWe), 32'(vt[i].e_we));
         chk($sformatf("v%0d_mem_addr", i), 32'(MemAddr), 32'(vt[i].e_addr));
         chk($sformatf("v%0d_mem_wdata", i), 32'(MemWData), 32'(vt[i].e_wd));
         chk($sformatf("v%0d_core_rvalid", i), 32'(CoreRValid), 32'(vt[i].e_crv));
         chk($sformatf("v%0d_core_rdata", i), 32'(CoreRData), 32'(vt[i].e_crd));
         chk($sformatf("v%0d_host_rvalid", i), 32'(HostRValid), 32'(vt[i].e_hrv));
         chk($sformatf("v%0d_host_rdata", i), 32'(HostRData), 32'(vt[i].e_hrd));
         chk($sformatf("v%0d_conflict", i), 32'(ConflictCnt), 32'(vt[i].e_cnt));
      end

      // Reset lands while the core read from vt[15] is pending, with a core
      // write already presented: the return and the write must both vanish.
      @(posedge Clk);
      #1;
      drive(T, T, 8'h50, 8'h99, F, F, 8'h00, 8'h00, F);
      Reset = 1'b0;
      #1;
      chk("midrst_core_rvalid", 32'(CoreRValid), 32'd0);
      chk("midrst_core_rdata", 32'(CoreRData), 32'd0);
      chk("midrst_core_gnt", 32'(CoreGnt), 32'd0);
      chk("midrst_mem_we", 32'(MemWe), 32'd0);
      chk("midrst_conflict", 32'(ConflictCnt), 32'd0);
      @(negedge Clk);
      drive(F, F, 8'h00, 8'h00, F, F, 8'h00, 8'h00, F);
      @(negedge Clk);
      Reset = 1'b1;
      cycle(F, F, 8'h00, 8'h00, F, F, 8'h00, 8'h00, F);
      chk("postrst_core_rvalid", 32'(CoreRValid), 32'd0);

      // Sustained contention: strict alternation starting with the core.
      for (int i = 0; i < 6; i++) begin
         cycle(T, F, 8'h10, 8'h00, T, F, 8'h30, 8'h00, F);
         chk($sformatf("alt%0d_core_gnt", i), 32'(CoreGnt), 32'((i % 2) == 0));
         chk($sformatf("alt%0d_host_gnt", i), 32'(HostGnt), 32'((i % 2) == 1));
      end
      cycle(F, F, 8'h00, 8'h00, F, F, 8'h00, 8'h00, F);
      chk("alt_conflict", 32'(ConflictCnt), 32'd6);
      chk("alt_last_host_rdata", 32'(HostRData), 32'h5A);

      // Counter saturation.
      reset_pulse();
      for (int i = 0; i < 300; i++) begin
         cycle(T, F, 8'h10, 8'h00, T, F, 8'h30, 8'h00, F);
         if (i == 255) chk("sat_at_255", 32'(ConflictCnt), 32'hFF);
      end
      cycle(F, F, 8'h00, 8'h00, F, F, 8'h00, 8'h00, F);
      chk("sat_conflict", 32'(ConflictCnt), 32'hFF);

      // Host lock sequence; start with priority on the host side.
      reset_pulse();
      cycle(T, F, 8'h10, 8'h00, F, F, 8'h00, 8'h00, F);
      chk("lk_pre_core_gnt", 32'(CoreGnt), 32'd1);
`ifdef MEM_ARB_LOCK_EN
      for (int i = 0; i < 4; i++) begin
         cycle(T, F, 8'h10, 8'h00, T, T, 8'h60, 8'h0F, T);
         chk($sformatf("lk%0d_core_gnt", i), 32'(CoreGnt), 32'd0);
         chk($sformatf("lk%0d_host_gnt", i), 32'(HostGnt), 32'd1);
         if (i > 0) chk($sformatf("lk%0d_state", i), 32'(DbgState), 32'(ARB_LOCKED));
      end
      cycle(T, F, 8'h10, 8'h00, T, T, 8'h61, 8'h0F, F);
      chk("lk_drop_core_gnt", 32'(CoreGnt), 32'd0);
      chk("lk_drop_host_gnt", 32'(HostGnt), 32'd1);
      cycle(T, F, 8'h10, 8'h00, T, T, 8'h62, 8'h0F, F);
      chk("lk_after_core_gnt", 32'(CoreGnt), 32'd1);
      chk("lk_after_host_gnt", 32'(HostGnt), 32'd0);
      chk("lk_conflict", 32'(ConflictCnt), 32'd1);
`else
      cycle(T, F, 8'h10, 8'h00, T, T, 8'h60, 8'h0F, T);
      chk("nolk0_host_gnt", 32'(HostGnt), 32'd1);
      cycle(T, F, 8'h10, 8'h00, T, T, 8'h61, 8'h0F, T);
      chk("nolk1_core_gnt", 32'(CoreGnt), 32'd1);
      chk("nolk1_host_gnt", 32'(HostGnt), 32'd0);
      chk("nolk1_state", 32'(DbgState), 32'(ARB_CORE_PRI));
      cycle(F, F, 8'h00, 8'h00, F, F, 8'h00, 8'h00, F);
      chk("nolk_conflict", 32'(ConflictCnt), 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
